// File: rtl/instr_info_writer_pkg.sv
// Shared widths, FIFO geometry and completion-lane indices for the instruction info writer.
package instr_info_writer_pkg;

    localparam int WF_ID_LENGTH            = 4;
    localparam int WF_PER_CU               = 10;
    localparam int ISSUE_INSTR_INFO_LENGTH = 8;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    localparam int DONE_VGPR_ALU = 0;
    localparam int DONE_VGPR_LSU = 1;
    localparam int DONE_SGPR_ALU = 2;
    localparam int DONE_SGPR_LSU = 3;
    localparam int DONE_LANES    = DONE_SGPR_LSU + 1;

    typedef struct packed {
        logic [WF_ID_LENGTH-1:0]            wfid;
        logic [ISSUE_INSTR_INFO_LENGTH-1:0] info;
    } fifo_entry_t;

    function automatic logic wfid_in_range(input logic [WF_ID_LENGTH-1:0] wfid);
        return int'(wfid) < WF_PER_CU;
    endfunction

endpackage

// File: rtl/instr_info_writer_fifo.sv
// In-order buffer for accepted offers; pointers wrap modulo FIFO_DEPTH.
module instr_info_fifo
    import instr_info_writer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty,
    output logic                  full
);

    logic [WIDTH-1:0]      mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (count == '0);
    assign full      = (int'(count) == FIFO_DEPTH);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
            end
            count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_info_writer.sv
// Buffers decoded instructions and writes each into the info table once its wavefront slot is free.
// Optional error tracking is compiled in with INSTR_INFO_WRITER_ERR_CHECK_EN.
module instr_info_writer
    import instr_info_writer_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WF_ID_LENGTH-1:0]            in_wfid,
    input  logic [ISSUE_INSTR_INFO_LENGTH-1:0] in_info,
    input  logic [DONE_LANES-1:0]              done_valid,
    input  logic [DONE_LANES*WF_ID_LENGTH-1:0] done_wfid,
    output logic                               f_decode_valid,
    output logic [WF_ID_LENGTH-1:0]            f_decode_wfid,
    output logic [ISSUE_INSTR_INFO_LENGTH-1:0] decode_wr_data,
    output logic [WF_PER_CU-1:0]               slot_busy,
    output logic [FIFO_CNT_W-1:0]              fifo_count,
    output logic                               err_spurious,
    output logic [WF_ID_LENGTH-1:0]            err_wfid
);

    fifo_entry_t          push_entry;
    fifo_entry_t          head_entry;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [WF_PER_CU-1:0] busy_next;

    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready && wfid_in_range(in_wfid);
    assign push_entry = '{wfid: in_wfid, info: in_info};
    assign pop        = !fifo_empty && !slot_busy[head_entry.wfid];

    instr_info_fifo #(
        .WIDTH($bits(fifo_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head_data(head_entry),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Clears first, then the pop's set, so a same-edge set wins.
    always_comb begin
        busy_next = slot_busy;
        for (int i = 0; i < DONE_LANES; i++) begin
            if (done_valid[i] && wfid_in_range(done_wfid[i*WF_ID_LENGTH +: WF_ID_LENGTH])) begin
                busy_next[done_wfid[i*WF_ID_LENGTH +: WF_ID_LENGTH]] = 1'b0;
            end
        end
        if (pop) begin
            busy_next[head_entry.wfid] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_decode_valid <= 1'b0;
            f_decode_wfid  <= '0;
            decode_wr_data <= '0;
            slot_busy      <= '0;
        end else begin
            f_decode_valid <= pop;
            slot_busy      <= busy_next;
            if (pop) begin
                f_decode_wfid  <= head_entry.wfid;
                decode_wr_data <= head_entry.info;
            end
        end
    end

`ifdef INSTR_INFO_WRITER_ERR_CHECK_EN
    logic                    err_hit;
    logic [WF_ID_LENGTH-1:0] err_hit_wfid;

    // Lane order gives priority; a dropped offer ranks after all lanes.
    always_comb begin
        err_hit      = 1'b0;
        err_hit_wfid = '0;
        for (int i = 0; i < DONE_LANES; i++) begin
            if (!err_hit && done_valid[i]
                && wfid_in_range(done_wfid[i*WF_ID_LENGTH +: WF_ID_LENGTH])
                && !slot_busy[done_wfid[i*WF_ID_LENGTH +: WF_ID_LENGTH]]) begin
                err_hit      = 1'b1;
                err_hit_wfid = done_wfid[i*WF_ID_LENGTH +: WF_ID_LENGTH];
            end
        end
        if (!err_hit && in_valid && in_ready && !wfid_in_range(in_wfid)) begin
            err_hit      = 1'b1;
            err_hit_wfid = in_wfid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spurious <= 1'b0;
            err_wfid     <= '0;
        end else if (err_hit && !err_spurious) begin
            err_spurious <= 1'b1;
            err_wfid     <= err_hit_wfid;
        end
    end
`else
    assign err_spurious = 1'b0;
    assign err_wfid     = '0;
`endif

endmodule

// File: tb/tb_instr_info_writer.sv
// Directed bench for instr_info_writer: vector table plus hand-written full-FIFO and reset sequences.
module tb_instr_info_writer;
    import instr_info_writer_pkg::*;

`ifdef INSTR_INFO_WRITER_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_wfid = '0;
    logic [7:0]  in_info = '0;
    logic [3:0]  done_valid = '0;
    logic [15:0] done_wfid = '0;
    logic        f_decode_valid;
    logic [3:0]  f_decode_wfid;
    logic [7:0]  decode_wr_data;
    logic [9:0]  slot_busy;
    logic [2:0]  fifo_count;
    logic        err_spurious;
    logic [3:0]  err_wfid;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    instr_info_writer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wfid       (in_wfid),
        .in_info       (in_info),
        .done_valid    (done_valid),
        .done_wfid     (done_wfid),
        .f_decode_valid(f_decode_valid),
        .f_decode_wfid (f_decode_wfid),
        .decode_wr_data(decode_wr_data),
        .slot_busy     (slot_busy),
        .fifo_count    (fifo_count),
        .err_spurious  (err_spurious),
        .err_wfid      (err_wfid)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  iw;
        logic [7:0]  ii;
        logic [3:0]  dv;
        logic [15:0] dw;
        logic        fdv;
        logic [3:0]  fw;
        logic [7:0]  fd;
        logic [9:0]  busy;
        logic [2:0]  cnt;
        logic        rdy;
        logic        err;
        logic [3:0]  ew;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] iw, input logic [7:0] ii,
                         input logic [3:0] dv, input logic [15:0] dw);
        in_valid   = iv;
        in_wfid    = iw;
        in_info    = ii;
        done_valid = dv;
        done_wfid  = dw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input int idx, input logic fdv, input logic [3:0] fw, input logic [7:0] fd,
                           input logic [9:0] busy, input logic [2:0] cnt, input logic rdy);
        chk("f_decode_valid", idx, 32'(f_decode_valid), 32'(fdv));
        chk("f_decode_wfid", idx, 32'(f_decode_wfid), 32'(fw));
        chk("decode_wr_data", idx, 32'(decode_wr_data), 32'(fd));
        chk("slot_busy", idx, 32'(slot_busy), 32'(busy));
        chk("fifo_count", idx, 32'(fifo_count), 32'(cnt));
        chk("in_ready", idx, 32'(in_ready), 32'(rdy));
    endtask

    task automatic chk_err(input int idx, input logic err, input logic [3:0] ew);
        chk("err_spurious", idx, 32'(err_spurious), 32'(err & ERR_EN));
        chk("err_wfid", idx, 32'(err_wfid), ERR_EN ? 32'(ew) : 32'd0);
    endtask

    initial begin
        //            iv  iw     ii     dv       dw         fdv fw     fd     busy      cnt   rdy err ew
        vecs[0]  = '{1, 4'd5,  8'hA5, 4'b0000, 16'h0000, 0, 4'd0, 8'h00, 10'h000, 3'd1, 1, 0, 4'd0};
        vecs[1]  = '{0, 4'd0,  8'h00, 4'b0000, 16'h0000, 1, 4'd5, 8'hA5, 10'h020, 3'd0, 1, 0, 4'd0};
        vecs[2]  = '{0, 4'd0,  8'h00, 4'b0000, 16'h0000, 0, 4'd5, 8'hA5, 10'h020, 3'd0, 1, 0, 4'd0};
        vecs[3]  = '{0, 4'd0,  8'h00, 4'b0001, 16'h0005, 0, 4'd5, 8'hA5, 10'h000, 3'd0, 1, 0, 4'd0};
        vecs[4]  = '{1, 4'd3,  8'h31, 4'b0000, 16'h0000, 0, 4'd5, 8'hA5, 10'h000, 3'd1, 1, 0, 4'd0};
        vecs[5]  = '{1, 4'd3,  8'h32, 4'b0000, 16'h0000, 1, 4'd3, 8'h31, 10'h008, 3'd1, 1, 0, 4'd0};
        vecs[6]  = '{1, 4'd7,  8'h71, 4'b0000, 16'h0000, 0, 4'd3, 8'h31, 10'h008, 3'd2, 1, 0, 4'd0};
        vecs[7]  = '{0, 4'd0,  8'h00, 4'b0000, 16'h0000, 0, 4'd3, 8'h31, 10'h008, 3'd2, 1, 0, 4'd0};
        vecs[8]  = '{0, 4'd0,  8'h00, 4'b0010, 16'h0030, 0, 4'd3, 8'h31, 10'h000, 3'd2, 1, 0, 4'd0};
        vecs[9]  = '{0, 4'd0,  8'h00, 4'b0000, 16'h0000, 1, 4'd3, 8'h32, 10'h008, 3'd1, 1, 0, 4'd0};
        vecs[10] = '{0, 4'd0,  8'h00, 4'b0000, 16'h0000, 1, 4'd7, 8'h71, 10'h088, 3'd0, 1, 0, 4'd0};
        vecs[11] = '{0, 4'd0,  8'h00, 4'b0011, 16'h0073, 0, 4'd7, 8'h71, 10'h000, 3'd0, 1, 0, 4'd0};
        vecs[12] = '{1, 4'd1,  8'h11, 4'b0000, 16'h0000, 0, 4'd7, 8'h71, 10'h000, 3'd1, 1, 0, 4'd0};
        vecs[13] = '{1, 4'd2,  8'h22, 4'b0000, 16'h0000, 1, 4'd1, 8'h11, 10'h002, 3'd1, 1, 0, 4'd0};
        vecs[14] = '{1, 4'd3,  8'h33, 4'b0000, 16'h0000, 1, 4'd2, 8'h22, 10'h006, 3'd1, 1, 0, 4'd0};
        vecs[15] = '{0, 4'd0,  8'h00, 4'b0000, 16'h0000, 1, 4'd3, 8'h33, 10'h00E, 3'd0, 1, 0, 4'd0};
        vecs[16] = '{0, 4'd0,  8'h00, 4'b1111, 16'h1321, 0, 4'd3, 8'h33, 10'h000, 3'd0, 1, 0, 4'd0};
        vecs[17] = '{0, 4'd0,  8'h00, 4'b0100, 16'h0900, 0, 4'd3, 8'h33, 10'h000, 3'd0, 1, 1, 4'd9};
        vecs[18] = '{1, 4'd12, 8'hCC, 4'b0000, 16'h0000, 0, 4'd3, 8'h33, 10'h000, 3'd0, 1, 1, 4'd9};
        vecs[19] = '{0, 4'd0,  8'h00, 4'b1000, 16'hE000, 0, 4'd3, 8'h33, 10'h000, 3'd0, 1, 1, 4'd9};
        vecs[20] = '{1, 4'd4,  8'h44, 4'b0000, 16'h0000, 0, 4'd3, 8'h33, 10'h000, 3'd1, 1, 1, 4'd9};
        vecs[21] = '{0, 4'd0,  8'h00, 4'b0000, 16'h0000, 1, 4'd4, 8'h44, 10'h010, 3'd0, 1, 1, 4'd9};
        vecs[22] = '{1, 4'd4,  8'h45, 4'b0001, 16'h0004, 0, 4'd4, 8'h44, 10'h000, 3'd1, 1, 1, 4'd9};
        vecs[23] = '{0, 4'd0,  8'h00, 4'b0001, 16'h0004, 1, 4'd4, 8'h45, 10'h010, 3'd0, 1, 1, 4'd9};
        vecs[24] = '{0, 4'd0,  8'h00, 4'b0001, 16'h0004, 0, 4'd4, 8'h45, 10'h000, 3'd0, 1, 1, 4'd9};

        // Asynchronous reset, checked before any clock edge sees it.
        #2 rst = 1'b1;
        #1;
        chk_out(-1, 0, 4'd0, 8'h00, 10'h000, 3'd0, 1);
        chk_err(-1, 0, 4'd0);
        step();
        step();
        #2 rst = 1'b0;
        step();
        chk("in_ready_after_reset", -1, 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].iv, vecs[i].iw, vecs[i].ii, vecs[i].dv, vecs[i].dw);
            step();
            chk_out(i, vecs[i].fdv, vecs[i].fw, vecs[i].fd, vecs[i].busy, vecs[i].cnt, vecs[i].rdy);
            chk_err(i, vecs[i].err, vecs[i].ew);
        end

        // Full FIFO behind a stalled head on slot 6; fifth offer held until a pop frees space.
        drive(1, 4'd6, 8'h60, 4'b0000, 16'h0000); step();
        chk_out(100, 0, 4'd4, 8'h45, 10'h000, 3'd1, 1);
        drive(1, 4'd6, 8'h61, 4'b0000, 16'h0000); step();
        chk_out(101, 1, 4'd6, 8'h60, 10'h040, 3'd1, 1);
        drive(1, 4'd1, 8'h01, 4'b0000, 16'h0000); step();
        chk_out(102, 0, 4'd6, 8'h60, 10'h040, 3'd2, 1);
        drive(1, 4'd2, 8'h02, 4'b0000, 16'h0000); step();
        chk_out(103, 0, 4'd6, 8'h60, 10'h040, 3'd3, 1);
        drive(1, 4'd3, 8'h03, 4'b0000, 16'h0000); step();
        chk_out(104, 0, 4'd6, 8'h60, 10'h040, 3'd4, 0);
        drive(1, 4'd8, 8'h08, 4'b0000, 16'h0000); step();
        chk_out(105, 0, 4'd6, 8'h60, 10'h040, 3'd4, 0);
        drive(1, 4'd8, 8'h08, 4'b0001, 16'h0006); step();
        chk_out(106, 0, 4'd6, 8'h60, 10'h000, 3'd4, 0);
        drive(1, 4'd8, 8'h08, 4'b0000, 16'h0000); step();
        chk_out(107, 1, 4'd6, 8'h61, 10'h040, 3'd3, 1);
        step();
        chk_out(108, 1, 4'd1, 8'h01, 10'h042, 3'd3, 1);
        drive(0, 4'd0, 8'h00, 4'b0000, 16'h0000); step();
        chk_out(109, 1, 4'd2, 8'h02, 10'h046, 3'd2, 1);
        step();
        chk_out(110, 1, 4'd3, 8'h03, 10'h04E, 3'd1, 1);
        step();
        chk_out(111, 1, 4'd8, 8'h08, 10'h14E, 3'd0, 1);
        chk_err(111, 1, 4'd9);

        // Reset mid-stall with three entries queued behind busy slots.
        drive(1, 4'd1, 8'h81, 4'b0000, 16'h0000); step();
        drive(1, 4'd2, 8'h82, 4'b0000, 16'h0000); step();
        drive(1, 4'd3, 8'h83, 4'b0000, 16'h0000); step();
        drive(0, 4'd0, 8'h00, 4'b0000, 16'h0000);
        chk_out(200, 0, 4'd8, 8'h08, 10'h14E, 3'd3, 1);
        #2 rst = 1'b1;
        #1;
        chk_out(201, 0, 4'd0, 8'h00, 10'h000, 3'd0, 1);
        chk_err(201, 0, 4'd0);
        step();
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out(210 + i, 0, 4'd0, 8'h00, 10'h000, 3'd0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_info_writer.md
INSTR_INFO_WRITER -- requirements
Module: instr_info_writer

Interface
REQ-001 SHALL have port clk, input, 1: single clock, rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1: a decoded instruction is offered.
REQ-004 SHALL have port in_ready, output, 1: the offer is accepted when in_valid and in_ready are both high at a rising edge.
REQ-005 SHALL have port in_wfid, input, `WF_ID_LENGTH: wavefront ID of the offer.
REQ-006 SHALL have port in_info, input, `ISSUE_INSTR_INFO_LENGTH: instruction info payload.
REQ-007 SHALL have port done_valid, input, 4: completion strobes, bit0 vgpr_alu, bit1 vgpr_lsu, bit2 sgpr_alu, bit3 sgpr_lsu.
REQ-008 SHALL have port done_wfid, input, 4*`WF_ID_LENGTH: wavefront ID per completion strobe, lane i in bits [i*W+W-1:i*W].
REQ-009 SHALL have port f_decode_valid, output, 1: table write strobe (registered).
REQ-010 SHALL have port f_decode_wfid, output, `WF_ID_LENGTH: table write slot (registered).
REQ-011 SHALL have port decode_wr_data, output, `ISSUE_INSTR_INFO_LENGTH: table write data (registered).
REQ-012 SHALL have port slot_busy, output, `WF_PER_CU: per-wavefront flag, set when the slot holds an uncompleted instruction.
REQ-013 SHALL have port fifo_count, output, 3: number of buffered entries, 0..4.
REQ-014 SHALL have port err_spurious, output, 1: sticky error flag (see Configuration).
REQ-015 SHALL have port err_wfid, output, `WF_ID_LENGTH: wavefront ID of the first error (see Configuration).

Function
REQ-016 SHALL buffer accepted offers in an in-order 4-entry FIFO.
REQ-017 SHALL drive in_ready = (fifo_count < 4), with no pass-through of a same-cycle pop into a full FIFO.
REQ-018 SHALL pop the FIFO head at an edge when the FIFO is non-empty and slot_busy[head wfid] is 0; at the same edge it SHALL set f_decode_valid=1, f_decode_wfid=head wfid, decode_wr_data=head info, and slot_busy[head wfid]=1.
REQ-019 SHALL hold f_decode_valid at 0 in every cycle without a pop, and SHALL hold f_decode_wfid/decode_wr_data at their last values.
REQ-020 SHALL stall a blocked head in order: later entries never bypass the head, even when their slot is free.
REQ-021 SHALL clear slot_busy[done_wfid lane i] at the edge for each asserted done_valid[i]; multiple lanes with the same or different IDs SHALL all clear in one cycle.
REQ-022 SHALL give completion clears effect from the next cycle: a head blocked by slot X pops no earlier than the edge after done for X.
REQ-023 SHALL let the set win when a pop and a done target the same wfid at the same edge.
REQ-024 SHALL consume and discard any offer with in_wfid >= `WF_PER_CU, with no FIFO entry and no write.
REQ-025 SHALL ignore any done_wfid >= `WF_PER_CU for clearing.
REQ-026 SHALL have a minimum latency of 2 edges from acceptance to f_decode_valid=1 (accept at edge k, write visible after edge k+1), with a sustained throughput of 1 write per cycle to distinct free slots.
REQ-027 SHALL support a simultaneous push and pop, leaving fifo_count unchanged; FIFO pointers SHALL wrap modulo 4.

Reset
REQ-028 SHALL, on rst high at any time, asynchronously set f_decode_valid=0, f_decode_wfid=0, decode_wr_data=0, slot_busy=0, fifo_count=0, pointers=0, err_spurious=0, err_wfid=0; in-flight entries SHALL be discarded.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL compile the error-check logic only when macro INSTR_INFO_WRITER_ERR_CHECK_EN is defined: err_spurious sets on a done for a non-busy slot, or on a dropped out-of-range offer, and err_wfid captures the offending ID of the first such event (lowest lane wins if simultaneous); both SHALL hold until reset.
REQ-031 SHALL, when INSTR_INFO_WRITER_ERR_CHECK_EN is not defined, tie err_spurious and err_wfid to 0, with all other behaviour identical.

Structure
REQ-032 SHALL take `WF_ID_LENGTH, `WF_PER_CU, `ISSUE_INSTR_INFO_LENGTH, the FIFO depth constant (4), and the done-lane index constants from the shared defines package.
REQ-033 SHALL implement the FIFO in one sub-module, instr_info_fifo, with width parameterized; busy tracking and output registers SHALL sit in the top level.

Verification
REQ-034 SHALL cover: after reset, offer wfid 5, info 0xA5 -> f_decode_valid pulses 1 cycle at edge k+1 with wfid 5 and data 0xA5; slot_busy[5]=1.
REQ-035 SHALL cover: two offers for wfid 3, then wfid 7 -> the first wfid 3 write occurs, and wfid 7 stalls behind the second wfid 3 until done_valid[1] for 3; then wfid 3 and wfid 7 write on consecutive cycles.
REQ-036 SHALL cover: 5 back-to-back offers to distinct free slots with a stalled head -> in_ready=0 at fifo_count=4; the 5th offer is held until a pop.
REQ-037 SHALL cover: done_valid=4'b1111 with IDs 1, 2, 3, 1 while slots 1-3 are busy -> all three clear next cycle; no error.
REQ-038 SHALL cover: with the macro defined, done for idle slot 9 -> err_spurious=1 and err_wfid=9, sticky; without the macro, both outputs stay 0.
REQ-039 SHALL cover: rst asserted mid-stall with 3 entries -> outputs zero immediately, fifo_count=0, and no write after reset release.
